// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state codes,
// default control-shadow length and the bundled enable record.
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] CTRL_WAIT = 2'd1;
  localparam logic [1:0] HALTED    = 2'd2;

  localparam int CTRL_STALL_CYC_DEF = 2;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: per-stage enables, IF/ID flush,
// ID/EX bubble, control-shadow and halt FSM. STALL_STATS_EN adds a stall-cycle counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int CTRL_STALL_CYC = CTRL_STALL_CYC_DEF,
  parameter int CNT_W          = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_hzd,
  input  logic       branch_hzd,
  input  logic       cntl_hzd,
  input  logic       id_hlt,
  input  logic       icache_stall,
  input  logic       dcache_stall,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       idex_we,
  output logic       exmem_we,
  output logic       memwb_we,
  output logic       halted,
  output logic [1:0] state_o
`ifdef STALL_STATS_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CTRL_STALL_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctl;
  logic             hzd;

  assign hzd = mem_hzd | branch_hzd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Illegal encoding 3 falls into the RUN branch and is steered back to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CTRL_WAIT: begin
        if (!dcache_stall) begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      HALTED: ;
      default: begin
        state_d = RUN;
        if (!dcache_stall && !hzd) begin
          if (id_hlt) begin
            state_d = HALTED;
          end else if (cntl_hzd) begin
            state_d = CTRL_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
    endcase
  end

  always_comb begin
    ctl = '0;
    if (!rst_n) begin
      ctl.ifid_flush  = 1'b1;
      ctl.idex_bubble = 1'b1;
    end else begin
      case (state_q)
        CTRL_WAIT: begin
          if (!dcache_stall) begin
            ctl.pc_we      = (cnt_q == '0);
            ctl.ifid_flush = 1'b1;
            ctl.idex_we    = 1'b1;
            ctl.exmem_we   = 1'b1;
            ctl.memwb_we   = 1'b1;
          end
        end
        HALTED: begin
          ctl.halted      = 1'b1;
          ctl.ifid_flush  = 1'b1;
          ctl.idex_bubble = 1'b1;
          ctl.idex_we     = !dcache_stall;
          ctl.exmem_we    = !dcache_stall;
          ctl.memwb_we    = !dcache_stall;
        end
        default: begin
          if (dcache_stall) begin
            ctl = '0;
          end else if (hzd) begin
            ctl.idex_bubble = 1'b1;
            ctl.idex_we     = 1'b1;
            ctl.exmem_we    = 1'b1;
            ctl.memwb_we    = 1'b1;
          end else if (id_hlt || cntl_hzd) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_we    = 1'b1;
            ctl.exmem_we   = 1'b1;
            ctl.memwb_we   = 1'b1;
          end else if (icache_stall) begin
            ctl.ifid_we    = 1'b1;
            ctl.ifid_flush = 1'b1;
            ctl.idex_we    = 1'b1;
            ctl.exmem_we   = 1'b1;
            ctl.memwb_we   = 1'b1;
          end else begin
            ctl.pc_we    = 1'b1;
            ctl.ifid_we  = 1'b1;
            ctl.idex_we  = 1'b1;
            ctl.exmem_we = 1'b1;
            ctl.memwb_we = 1'b1;
          end
        end
      endcase
    end
  end

  assign pc_we       = ctl.pc_we;
  assign ifid_we     = ctl.ifid_we;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_bubble = ctl.idex_bubble;
  assign idex_we     = ctl.idex_we;
  assign exmem_we    = ctl.exmem_we;
  assign memwb_we    = ctl.memwb_we;
  assign halted      = ctl.halted;
  assign state_o     = state_q;

`ifdef STALL_STATS_EN
  logic stat_en;

  assign stat_en = !ctl.pc_we && !ctl.halted;

  sat_counter #(.W(16)) u_stats (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stat_en),
    .cnt   (stall_cycles)
  );
`endif

endmodule
